// File: rtl/exstage_mc.sv
// Execute stage for the rv32i pipeline: single-cycle integer ALU plus a
// multi-cycle iterative shifter, valid/ready on both sides and a result
// register that holds its contents under downstream back-pressure.
module exstage_mc #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1,
  parameter int RD_W       = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [2:0]      f3_i,
  input  logic            alt_i,
  input  logic            is_imm_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] rdataa_i,
  input  logic [XLEN-1:0] rdatab_i,
  input  logic [RD_W-1:0] rd_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic [RD_W-1:0] rd_o,
  output logic            busy_o
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  localparam logic [1:0] K_SLL = 2'd0;
  localparam logic [1:0] K_SRL = 2'd1;
  localparam logic [1:0] K_SRA = 2'd2;

  localparam logic [SHW:0] STEP = SHIFT_STEP[SHW:0];

  // One shifter pass; arithmetic shifts replicate the current MSB, which is
  // always the original sign bit because earlier passes preserved it.
  function automatic logic [XLEN-1:0] shift_by(input logic [XLEN-1:0] v,
                                               input logic [SHW:0]    s,
                                               input logic [1:0]      kind);
    logic signed [XLEN-1:0] sv;
    sv = signed'(v);
    case (kind)
      K_SLL:   return v << s;
      K_SRA:   return unsigned'(sv >>> s);
      default: return v >> s;
    endcase
  endfunction

  logic [0:0]      state_q, state_d;
  logic [XLEN-1:0] work_q, work_d;
  logic [SHW-1:0]  rem_q, rem_d;
  logic [1:0]      kind_q, kind_d;
  logic [RD_W-1:0] rdp_q, rdp_d;
  logic            ov_q, ov_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [RD_W-1:0] rdo_q, rdo_d;

  logic [XLEN-1:0] op2;
  logic [SHW-1:0]  shamt;
  logic            is_shift;
  logic            is_sub;
  logic [XLEN-1:0] alu_res;
  logic            accept;
  logic            start_shift;
  logic            fast_wr;
  logic [SHW:0]    rem_ext;
  logic [SHW:0]    step_s;
  logic [SHW:0]    rem_left;
  logic            last_step;
  logic [XLEN-1:0] shifted;

  // Operand selection and the single-cycle ALU result.
  always_comb begin
    op2      = is_imm_i ? imm_i : rdatab_i;
    shamt    = op2[SHW-1:0];
    is_shift = (f3_i == 3'd1) || (f3_i == 3'd5);
    is_sub   = (f3_i == 3'd0) && alt_i && !is_imm_i;
    alu_res  = '0;
    case (f3_i)
      3'd0:    alu_res = is_sub ? (rdataa_i - op2) : (rdataa_i + op2);
      3'd2:    alu_res = {{(XLEN-1){1'b0}}, ($signed(rdataa_i) < $signed(op2))};
      3'd3:    alu_res = {{(XLEN-1){1'b0}}, (rdataa_i < op2)};
      3'd4:    alu_res = rdataa_i ^ op2;
      3'd6:    alu_res = rdataa_i | op2;
      3'd7:    alu_res = rdataa_i & op2;
      default: alu_res = rdataa_i;  // shift by zero passes rs1 through
    endcase
  end

  // Handshake decode and the per-cycle shifter step.
  always_comb begin
    in_ready_o  = (state_q == S_IDLE) && (!ov_q || out_ready_i);
    accept      = in_valid_i && in_ready_o;
    start_shift = accept && is_shift && (shamt != '0);
    fast_wr     = accept && !start_shift;
    rem_ext     = {1'b0, rem_q};
    step_s      = (rem_ext < STEP) ? rem_ext : STEP;
    rem_left    = rem_ext - step_s;
    last_step   = (state_q == S_SHIFT) && (rem_left == '0);
    shifted     = shift_by(work_q, step_s, kind_q);
  end

  // Next-state for the FSM, the shifter working set and the output register.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    kind_d  = kind_q;
    rdp_d   = rdp_q;
    ov_d    = ov_q;
    res_d   = res_q;
    rdo_d   = rdo_q;

    if (ov_q && out_ready_i) begin
      ov_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start_shift) begin
          state_d = S_SHIFT;
          work_d  = rdataa_i;
          rem_d   = shamt;
          kind_d  = (f3_i == 3'd1) ? K_SLL : (alt_i ? K_SRA : K_SRL);
          rdp_d   = rd_i;
        end else if (fast_wr) begin
          ov_d  = 1'b1;
          res_d = alu_res;
          rdo_d = rd_i;
        end
      end
      default: begin
        work_d = shifted;
        rem_d  = rem_left[SHW-1:0];
        if (last_step) begin
          state_d = S_IDLE;
          ov_d    = 1'b1;
          res_d   = shifted;
          rdo_d   = rdp_q;
        end
      end
    endcase
  end

  // State registers; reset drops any in-flight shift and empties the output.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      kind_q  <= K_SLL;
      rdp_q   <= '0;
      ov_q    <= 1'b0;
      res_q   <= '0;
      rdo_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      kind_q  <= kind_d;
      rdp_q   <= rdp_d;
      ov_q    <= ov_d;
      res_q   <= res_d;
      rdo_q   <= rdo_d;
    end
  end

  assign out_valid_o = ov_q;
  assign result_o    = res_q;
  assign rd_o        = rdo_q;
  assign busy_o      = (state_q == S_SHIFT);

endmodule

// File: tb/tb_exstage_mc.sv
// Bench for exstage_mc: directed scenarios plus randomized ops against a
// plain-arithmetic ALU/latency model; a second instance covers SHIFT_STEP=4.
module tb_exstage_mc;

  localparam int STEP1 = 1;
  localparam int STEP4 = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        in_valid_i, in_valid4;
  logic        in_ready_o, in_ready4;
  logic [2:0]  f3_i;
  logic        alt_i, is_imm_i;
  logic [31:0] imm_i, rdataa_i, rdatab_i;
  logic [4:0]  rd_i;
  logic        out_valid_o, ov4;
  logic        out_ready_i, out_ready4;
  logic [31:0] result_o, res4;
  logic [4:0]  rd_o, rd4;
  logic        busy_o, busy4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exstage_mc #(.XLEN(32), .SHIFT_STEP(STEP1), .RD_W(5)) dut (
    .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .f3_i(f3_i), .alt_i(alt_i), .is_imm_i(is_imm_i), .imm_i(imm_i),
    .rdataa_i(rdataa_i), .rdatab_i(rdatab_i), .rd_i(rd_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .result_o(result_o),
    .rd_o(rd_o), .busy_o(busy_o)
  );

  exstage_mc #(.XLEN(32), .SHIFT_STEP(STEP4), .RD_W(5)) dut4 (
    .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid4), .in_ready_o(in_ready4),
    .f3_i(f3_i), .alt_i(alt_i), .is_imm_i(is_imm_i), .imm_i(imm_i),
    .rdataa_i(rdataa_i), .rdatab_i(rdatab_i), .rd_i(rd_i),
    .out_valid_o(ov4), .out_ready_i(out_ready4), .result_o(res4),
    .rd_o(rd4), .busy_o(busy4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural result of one RV32I op.
  function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic alt,
                                          input logic im, input logic [31:0] imm,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [31:0] o2;
    int sh;
    o2 = im ? imm : b;
    sh = int'(o2 % 32);
    case (f3)
      3'd0: return (alt && !im) ? a - o2 : a + o2;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(o2)) ? 32'd1 : 32'd0;
      3'd3: return (a < o2) ? 32'd1 : 32'd0;
      3'd4: return a ^ o2;
      3'd5: return alt ? unsigned'($signed(a) >>> sh) : a >> sh;
      3'd6: return a | o2;
      default: return a & o2;
    endcase
  endfunction

  // Number of shifter cycles the op occupies (0 for single-cycle ops).
  function automatic int ref_shift_cycles(input logic [2:0] f3, input logic im,
                                          input logic [31:0] imm, input logic [31:0] b,
                                          input int step);
    logic [31:0] o2;
    int sh;
    o2 = im ? imm : b;
    sh = int'(o2 % 32);
    if ((f3 == 3'd1 || f3 == 3'd5) && sh != 0) return (sh + step - 1) / step;
    return 0;
  endfunction

  task automatic drive(input logic [2:0] f3, input logic alt, input logic im,
                       input logic [31:0] imm, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    f3_i = f3; alt_i = alt; is_imm_i = im; imm_i = imm;
    rdataa_i = a; rdatab_i = b; rd_i = rd;
  endtask

  // Issue one op on the STEP=1 instance and check result, rd, latency, busy.
  // Entered and left at 1 time unit after a rising edge.
  task automatic do_op(input logic [2:0] f3, input logic alt, input logic im,
                       input logic [31:0] imm, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    logic [31:0] exp;
    int k, n, bz;
    exp = ref_alu(f3, alt, im, imm, a, b);
    k   = ref_shift_cycles(f3, im, imm, b, STEP1);
    drive(f3, alt, im, imm, a, b, rd);
    in_valid_i = 1'b1;
    @(negedge clk);
    chk("in_ready_before_accept", 32'(in_ready_o), 32'd1);
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    drive(3'd0, 1'b0, 1'b0, $urandom, $urandom, $urandom, 5'(~rd));
    n = 1; bz = 0;
    while (!out_valid_o && n < 100) begin
      if (busy_o) begin
        bz++;
        chk("in_ready_while_busy", 32'(in_ready_o), 32'd0);
      end
      @(posedge clk); #1;
      n++;
    end
    chk("out_valid", 32'(out_valid_o), 32'd1);
    chk("result", result_o, exp);
    chk("rd", 32'(rd_o), 32'(rd));
    chk("latency_edges", 32'(n), 32'(k + 1));
    chk("busy_cycles", 32'(bz), 32'(k));
    if (k == 0) chk("busy_zero", 32'(busy_o), 32'd0);
  endtask

  initial begin
    logic [31:0] held_res, new_exp;
    logic [4:0]  held_rd;
    int n, pulses;

    rst_i = 1'b1; in_valid_i = 1'b0; in_valid4 = 1'b0;
    out_ready_i = 1'b1; out_ready4 = 1'b1;
    drive(3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_rd", 32'(rd_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_in_ready", 32'(in_ready_o), 32'd1);
    @(posedge clk); #1;
    rst_i = 1'b0;

    // 1: ADD then SUB back to back
    drive(3'd0, 1'b0, 1'b0, 32'd0, 32'd7, 32'd5, 5'd1);
    in_valid_i = 1'b1;
    @(posedge clk); #1;
    chk("t1_add_valid", 32'(out_valid_o), 32'd1);
    chk("t1_add", result_o, 32'h0000000C);
    chk("t1_rd1", 32'(rd_o), 32'd1);
    chk("t1_ready", 32'(in_ready_o), 32'd1);
    drive(3'd0, 1'b1, 1'b0, 32'd0, 32'd5, 32'd7, 5'd2);
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    chk("t1_sub_valid", 32'(out_valid_o), 32'd1);
    chk("t1_sub", result_o, 32'hFFFFFFFE);
    chk("t1_rd2", 32'(rd_o), 32'd2);
    chk("t1_ready2", 32'(in_ready_o), 32'd1);

    // 2: SLTI, SLTU, ADDI with alt set
    do_op(3'd2, 1'b0, 1'b1, 32'd1, 32'hFFFFFFFF, 32'd0, 5'd3);
    chk("t2_slti", result_o, 32'd1);
    do_op(3'd3, 1'b0, 1'b0, 32'd0, 32'hFFFFFFFF, 32'd1, 5'd4);
    chk("t2_sltu", result_o, 32'd0);
    do_op(3'd0, 1'b1, 1'b1, 32'd3, 32'd2, 32'd0, 5'd5);
    chk("t2_addi", result_o, 32'd5);

    // 3: SRA by 5, STEP=1 (5 busy cycles)
    do_op(3'd5, 1'b1, 1'b0, 32'd0, 32'h80000000, 32'd5, 5'd6);
    chk("t3_sra", result_o, 32'hFC000000);

    // 3b: same op on the STEP=4 instance (2 busy cycles)
    drive(3'd5, 1'b1, 1'b0, 32'd0, 32'h80000000, 32'd5, 5'd7);
    in_valid4 = 1'b1;
    @(negedge clk);
    chk("t3b_ready", 32'(in_ready4), 32'd1);
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    n = 1; pulses = 0;
    while (!ov4 && n < 100) begin
      if (busy4) pulses++;
      @(posedge clk); #1;
      n++;
    end
    chk("t3b_latency_edges", 32'(n), 32'd3);
    chk("t3b_busy_cycles", 32'(pulses), 32'd2);
    chk("t3b_sra", res4, 32'hFC000000);
    chk("t3b_rd", 32'(rd4), 32'd7);

    // 4: SLL with shamt field 0 (upper rs2 bits ignored)
    do_op(3'd1, 1'b0, 1'b0, 32'd0, 32'h12345678, 32'h00000020, 5'd8);
    chk("t4_sll0", result_o, 32'h12345678);

    // 5: back-pressure
    @(posedge clk); #1;            // drain previous result
    out_ready_i = 1'b0;
    do_op(3'd4, 1'b0, 1'b0, 32'd0, 32'hA5A5A5A5, 32'h0F0F0F0F, 5'd9);
    held_res = result_o; held_rd = rd_o;
    chk("t5_held_val", held_res, 32'hAAAAAAAA);
    drive(3'd6, 1'b0, 1'b1, 32'h000000F0, 32'h0000000F, 32'd0, 5'd10);
    new_exp = 32'h000000FF;
    in_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("t5_stall_valid", 32'(out_valid_o), 32'd1);
      chk("t5_stall_result", result_o, held_res);
      chk("t5_stall_rd", 32'(rd_o), 32'(held_rd));
      chk("t5_stall_ready", 32'(in_ready_o), 32'd0);
    end
    out_ready_i = 1'b1;
    @(negedge clk);
    chk("t5_ready_on_drain", 32'(in_ready_o), 32'd1);
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    chk("t5_new_valid", 32'(out_valid_o), 32'd1);
    chk("t5_new_result", result_o, new_exp);
    chk("t5_new_rd", 32'(rd_o), 32'd10);
    @(posedge clk); #1;
    chk("t5_drained", 32'(out_valid_o), 32'd0);

    // Randomized ops against the model
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  rf3;
      logic [31:0] rimm, rb;
      rf3  = 3'($urandom_range(0, 7));
      rimm = 32'($signed(12'($urandom)));
      rb   = $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb & 32'hFFFFFFE0;  // force shamt 0 sometimes
      do_op(rf3, 1'($urandom), 1'($urandom), rimm, $urandom, rb, 5'($urandom));
    end

    // 6: reset during SRL by 20
    @(posedge clk); #1;
    drive(3'd5, 1'b0, 1'b0, 32'd0, 32'hF0000000, 32'd20, 5'd11);
    in_valid_i = 1'b1;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("t6_busy_before", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    #1;
    chk("t6_rst_busy", 32'(busy_o), 32'd0);
    chk("t6_rst_valid", 32'(out_valid_o), 32'd0);
    chk("t6_rst_result", result_o, 32'd0);
    chk("t6_rst_rd", 32'(rd_o), 32'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid_o) pulses++;
    end
    chk("t6_no_pulse", 32'(pulses), 32'd0);
    @(posedge clk); #1;
    do_op(3'd0, 1'b0, 1'b0, 32'd0, 32'd100, 32'd23, 5'd12);
    chk("t6_add_after", result_o, 32'd123);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
